div_32: RTL and testbench

Sequential 32-bit radix-2 restoring divider for the processor execute stage. Operands arrive from the register-read/ALU path. Each iteration performs one trial subtraction of the divisor from the partial remainder and keeps or discards the difference based on its sign. Quotient and remainder are returned to writeback with a one-cycle ready pulse; the pipeline stalls on `ctrl_div` until that pulse.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 21 ++
 rtl/div_32.sv | 164 ++++++++++++++++
 tb/tb_div_32.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Signed operation is enabled by defining DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DIV_ITERS - 1);
    localparam logic [31:0]      DBZ_QUOTIENT = 32'd0;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the difference only when it is non-negative.
module div_step (
    input  logic [31:0] rem,
    input  logic        dvd_bit,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and bit 32 of the difference is a reliable sign bit.
    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[32];
    assign next_rem = diff[32] ? shifted[31:0] : diff[31:0];

endmodule

// File: rtl/div_32.sv
// Sequential 32-bit radix-2 restoring divider with registered outputs.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise unsigned.
module div_32
    import div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_div,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_exception,
    output logic        data_resultRDY
);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvd_q;
    logic [31:0]      dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic             ovf_q;

    logic load_ops;
    logic do_step;
    logic load_out;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        a_neg;
    logic        b_neg;
    logic        ovf_in;
    logic        dbz_in;

    logic [31:0] step_rem;
    logic        step_qbit;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

`ifdef DIV_SIGNED_EN
    assign a_neg  = data_operandA[31];
    assign b_neg  = data_operandB[31];
    assign a_mag  = abs32(data_operandA);
    assign b_mag  = abs32(data_operandB);
    assign ovf_in = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
`else
    assign a_neg  = 1'b0;
    assign b_neg  = 1'b0;
    assign a_mag  = data_operandA;
    assign b_mag  = data_operandB;
    assign ovf_in = 1'b0;
`endif

    assign dbz_in = (data_operandB == 32'd0);

    div_step u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[31]),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .q_bit    (step_qbit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start strobe always (re)enters RUN, aborting any op.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_div) state_d = StRun;
            end
            StRun: begin
                if (ctrl_div) begin
                    state_d = StRun;
                end else if (dbz_q || (cnt_q == CNT_LAST)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = ctrl_div ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        load_ops = ctrl_div;
        do_step  = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            StRun:   do_step  = ~ctrl_div & ~dbz_q;
            StDone:  load_out = 1'b1;
            default: ;
        endcase
    end

    // Operand, partial remainder and iteration counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (load_ops) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            // On divide-by-zero the raw dividend is parked here as the remainder.
            dvd_q     <= dbz_in ? data_operandA : a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= dbz_in;
            ovf_q     <= ovf_in;
        end else if (do_step) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= step_rem;
            dvd_q <= {dvd_q[30:0], step_qbit};
        end
    end

    assign quo_fix = neg_quo_q ? (~dvd_q + 32'd1) : dvd_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    // Output registers; updated only on leaving DONE, held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= load_out;
            if (load_out) begin
                if (dbz_q) begin
                    data_result    <= DBZ_QUOTIENT;
                    data_remainder <= dvd_q;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= quo_fix;
                    data_remainder <= rem_fix;
                    data_exception <= ovf_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: directed cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_div_32;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_fail   = 0;

    div_32 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic e);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = a;
            e = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
                e = 1'b1;
            end else begin
                q = sa / sb;
                r = sa % sb;
                e = 1'b0;
            end
`else
            q = a / b;
            r = a % b;
            e = 1'b0;
`endif
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                          input bit pulse_chk);
        int          n;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        start_op(a, b);
        wait_rdy(n);
        ref_div(a, b, q, r, e);
        check_eq($sformatf("%s latency", tag), n, (b == 32'd0) ? 32'd2 : 32'd33);
        check_eq($sformatf("%s quotient", tag), data_result, q);
        check_eq($sformatf("%s remainder", tag), data_remainder, r);
        check_eq($sformatf("%s exception", tag), {31'd0, data_exception}, {31'd0, e});
        if (pulse_chk) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("%s rdy_pulse", tag), {31'd0, data_resultRDY}, 32'd0);
            check_eq($sformatf("%s hold", tag), data_result, q);
        end
    endtask

    initial begin
        int          cnt;
        int          edge_no;
        logic [31:0] got_q;
        logic [31:0] got_r;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        reset         = 1'b1;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        check_eq("reset result", data_result, 32'd0);
        check_eq("reset remainder", data_remainder, 32'd0);
        check_eq("reset exception", {31'd0, data_exception}, 32'd0);
        check_eq("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_op(32'd100, 32'd7, "100/7", 1'b1);
        run_op(32'd5, 32'd0, "5/0", 1'b1);
`ifdef DIV_SIGNED_EN
        run_op(-32'sd100, 32'd7, "-100/7", 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "ovf", 1'b1);
        run_op(32'd100, -32'sd7, "100/-7", 1'b1);
`else
        run_op(32'hFFFF_FFFF, 32'd2, "max/2", 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "big/max", 1'b1);
`endif

        // Restart mid-RUN: only the second operation may produce RDY.
        start_op(32'd100, 32'd7);
        cnt     = 0;
        edge_no = 0;
        got_q   = '0;
        got_r   = '0;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clock);
            if (e == 10) begin
                ctrl_div      = 1'b1;
                data_operandA = 32'd50;
                data_operandB = 32'd5;
            end
            @(posedge clock);
            #1;
            ctrl_div = 1'b0;
            if (data_resultRDY) begin
                cnt++;
                edge_no = e;
                got_q   = data_result;
                got_r   = data_remainder;
            end
        end
        check_eq("restart rdy_count", cnt, 32'd1);
        check_eq("restart rdy_edge", edge_no, 32'd43);
        check_eq("restart quotient", got_q, 32'd10);
        check_eq("restart remainder", got_r, 32'd0);

        // Asynchronous reset mid-RUN clears held outputs and drops the op.
        start_op(32'd100, 32'd7);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midreset result", data_result, 32'd0);
        check_eq("midreset remainder", data_remainder, 32'd0);
        check_eq("midreset exception", {31'd0, data_exception}, 32'd0);
        check_eq("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cnt   = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
        check_eq("midreset no_rdy", cnt, 32'd0);
        run_op(32'd1000, 32'd3, "post_reset", 1'b1);

        // Randomized operands, issued back-to-back in the RDY cycle.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            case (sel)
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 255);
                4:       b = 32'hFFFF_FFFF;
                5: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                default: b = $urandom;
            endcase
            run_op(a, b, $sformatf("rand%0d", i), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
